// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Brief    : IF->ID instruction queue: small FIFO with valid/ready handshake,
//            back-pressure to fetch and redirect flush with shadow-beat drain.
// Revision : 1.0
// ============================================================================
module if_id_queue #(
    parameter int               DEPTH  = 2,
    parameter int               WIDTH  = 32,
    parameter int               SHADOW = 1,
    parameter logic [WIDTH-1:0] NOP    = 'h13
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [WIDTH-1:0]           fetch_pc,
    input  logic [WIDTH-1:0]           fetch_instr,
    output logic                       fetch_ready,
    input  logic                       flush,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [WIDTH-1:0]           id_pc,
    output logic [WIDTH-1:0]           id_instr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_sh_w   = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;
    localparam logic [c_addr_w:0]   c_depth  = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_sh_w-1:0]   c_shadow = c_sh_w'(SHADOW);

    logic [WIDTH-1:0]    r_mem_pc    [DEPTH];
    logic [WIDTH-1:0]    r_mem_instr [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic [c_sh_w-1:0]   r_shadow_cnt;

    logic w_nonempty;
    logic w_draining;
    logic w_push;
    logic w_pop;
    logic w_discard;

    assign w_nonempty  = (r_count != '0);
    assign w_draining  = (r_shadow_cnt != '0);
    // No full bypass: a full queue refuses fetch even if decode pops this cycle.
    assign fetch_ready = (r_count < c_depth) | w_draining;
    assign w_push      = fetch_valid & fetch_ready & ~flush & ~w_draining;
    assign w_pop       = w_nonempty & id_ready & ~flush;
    assign w_discard   = fetch_valid & ~flush & w_draining;

    assign id_valid  = w_nonempty;
    assign id_pc     = w_nonempty ? r_mem_pc[r_rd_ptr]    : '0;
    assign id_instr  = w_nonempty ? r_mem_instr[r_rd_ptr] : NOP;
    assign occupancy = r_count;

    // Storage is intentionally not reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= fetch_pc;
            r_mem_instr[r_wr_ptr] <= fetch_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_shadow_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_shadow_cnt <= c_shadow;
        end else begin
            if (w_push) begin
                r_wr_ptr <= c_addr_w'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= c_addr_w'(r_rd_ptr + 1'b1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Stale in-flight beats are swallowed one per fetch_valid cycle.
            if (w_discard) begin
                r_shadow_cnt <= r_shadow_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Brief    : Self-checking bench for if_id_queue: directed scenarios with
//            literal expectations plus randomized traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_if_id_queue;

    localparam int               DEPTH  = 2;
    localparam int               WIDTH  = 32;
    localparam int               SHADOW = 1;
    localparam logic [WIDTH-1:0] NOP    = 32'h0000_0013;

    logic             clk;
    logic             reset;
    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_instr;
    logic             fetch_ready;
    logic             flush;
    logic             id_valid;
    logic             id_ready;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_instr;
    logic [1:0]       occupancy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference model: a plain queue of {pc, instr} plus a shadow counter.
    logic [2*WIDTH-1:0] mq[$];
    int                 msh = 0;

    if_id_queue #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .SHADOW (SHADOW),
        .NOP    (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        bit full;
        if (!reset) begin
            mq.delete();
            msh = 0;
        end else begin
            full = (mq.size() >= DEPTH);
            if (flush) begin
                mq.delete();
                msh = SHADOW;
            end else begin
                if (id_ready && mq.size() > 0) void'(mq.pop_front());
                if (fetch_valid) begin
                    if (msh != 0) msh--;
                    else if (!full) mq.push_back({fetch_pc, fetch_instr});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_id_valid", 32'(id_valid), 32'(mq.size() != 0));
            chk("m_id_pc", id_pc, (mq.size() != 0) ? mq[0][2*WIDTH-1:WIDTH] : 32'h0);
            chk("m_id_instr", id_instr, (mq.size() != 0) ? mq[0][WIDTH-1:0] : NOP);
            chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
            chk("m_fetch_ready", 32'(fetch_ready), 32'((mq.size() < DEPTH) || (msh != 0)));
        end
    end

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic rdy);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = ins;
        flush       = fl;
        id_ready    = rdy;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);

        // T1: reset values while held low
        #20;
        chk("t1_id_valid", 32'(id_valid), 0);
        chk("t1_id_instr", id_instr, 32'h13);
        chk("t1_id_pc", id_pc, 0);
        chk("t1_fetch_ready", 32'(fetch_ready), 1);
        chk("t1_occupancy", 32'(occupancy), 0);
        #4 reset = 1'b1;
        chk_en = 1;

        // T2: streaming with id_ready=1
        @(negedge clk); drive(1, 0, 32'hA, 0, 1);
        @(negedge clk);
        chk("t2_pc0", id_pc, 0); chk("t2_instrA", id_instr, 32'hA); chk("t2_occ1", 32'(occupancy), 1);
        drive(1, 4, 32'hB, 0, 1);
        @(negedge clk);
        chk("t2_pc4", id_pc, 4); chk("t2_instrB", id_instr, 32'hB); chk("t2_occ1b", 32'(occupancy), 1);
        drive(1, 8, 32'hC, 0, 1);
        @(negedge clk);
        chk("t2_pc8", id_pc, 8); chk("t2_instrC", id_instr, 32'hC);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t2_empty", 32'(id_valid), 0); chk("t2_nop", id_instr, 32'h13);

        // T3: fill, back-pressure, then a single pop
        drive(1, 0, 32'h100, 0, 0);
        @(negedge clk); drive(1, 4, 32'h104, 0, 0);
        @(negedge clk);
        chk("t3_occ2", 32'(occupancy), 2); chk("t3_not_ready", 32'(fetch_ready), 0);
        drive(1, 8, 32'h108, 0, 1);
        @(negedge clk);
        chk("t3_head4", id_pc, 4); chk("t3_ready", 32'(fetch_ready), 1); chk("t3_occ1", 32'(occupancy), 1);
        drive(1, 8, 32'h108, 0, 0);
        @(negedge clk); drive(1, 12, 32'h10C, 0, 1);
        @(negedge clk); drive(1, 12, 32'h10C, 0, 0);
        @(negedge clk);
        chk("t3_head8", id_pc, 8); chk("t3_occ2b", 32'(occupancy), 2);

        // T4: flush with a concurrent push, then shadow drain
        drive(1, 16, 32'h110, 1, 1);
        @(negedge clk);
        chk("t4_occ0", 32'(occupancy), 0); chk("t4_invalid", 32'(id_valid), 0);
        chk("t4_shadow_ready", 32'(fetch_ready), 1);
        drive(1, 20, 32'h114, 0, 0);
        @(negedge clk);
        chk("t4_discard", 32'(id_valid), 0);
        drive(1, 44, 32'h12C, 0, 0);
        @(negedge clk);
        chk("t4_pc44", id_pc, 44); chk("t4_instr44", id_instr, 32'h12C);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);

        // T5: pointer wrap over five push/pop pairs
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h200 + 4 * i, 32'h5000 + i, 0, 1);
            @(negedge clk);
            chk("t5_wrap_pc", id_pc, 32'h200 + 4 * i);
            chk("t5_wrap_occ", 32'(occupancy), 1);
        end
        drive(0, 0, 0, 0, 1);
        @(negedge clk);

        // T6: async reset while full, then while draining shadow
        drive(1, 32'h300, 32'h300, 0, 0);
        @(negedge clk); drive(1, 32'h304, 32'h304, 0, 0);
        @(negedge clk);
        chk("t6_full", 32'(occupancy), 2);
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'(id_valid), 0); chk("t6_async_occ", 32'(occupancy), 0);
        chk("t6_async_nop", id_instr, 32'h13); chk("t6_async_ready", 32'(fetch_ready), 1);
        #1 reset = 1'b1;
        @(negedge clk); drive(0, 0, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk); drive(1, 32'h400, 32'h400, 0, 0);
        @(negedge clk);
        chk("t6_shadow_cleared", id_pc, 32'h400);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 1);
        repeat (4) @(negedge clk);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
